// File: rtl/ram_arbiter.sv
// Arbitrates N_REQ requesters onto one 1R/1W registered-read Ram and runs a zero-fill clear sweep.
// Define RAM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int N_REQ  = 2,
    parameter int SIZE   = 2**ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      clear,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ram_ra,
    output logic [ADDR_W-1:0]         ram_wa,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_result
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [N_REQ-1:0]    r_rsp_vld_p1;

    logic                w_any;
    logic [PTR_W-1:0]    w_gidx;
    logic [N_REQ-1:0]    w_grant;
    logic                w_acc;
    logic [ADDR_W-1:0]   w_gaddr;
    logic [DATA_W-1:0]   w_gwdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]    r_ptr;

    // Scan from farthest to nearest so the requester closest to r_ptr is the last to overwrite
    always_comb begin : pick_rr
        logic [PTR_W-1:0] v_idx;
        w_any  = 1'b0;
        w_gidx = '0;
        v_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_gidx = v_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
        end
    end
`else
    always_comb begin : pick_fixed
        logic [PTR_W-1:0] v_idx;
        w_any  = 1'b0;
        w_gidx = '0;
        v_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = PTR_W'(k);
            if (req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_gidx = v_idx;
            end
        end
    end
`endif

    // A clear pulse steals the cycle so the sweep never races a granted access
    always_comb begin
        w_grant = '0;
        if (w_any && (r_state == IDLE) && !clear) begin
            w_grant = N_REQ'(1) << w_gidx;
        end
    end

    assign w_acc     = |w_grant;
    assign req_ready = w_grant;
    assign w_gaddr   = req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
    assign w_gwdata  = req_wdata[int'(w_gidx)*DATA_W +: DATA_W];

    always_comb begin
        ram_ra   = w_gaddr;
        ram_wa   = w_gaddr;
        ram_data = w_gwdata;
        ram_we   = w_acc & req_we[w_gidx];
        if (r_state == CLEAR) begin
            ram_wa   = r_cnt;
            ram_data = '0;
            ram_we   = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == ADDR_W'(SIZE - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p0 -> p1: read acceptance becomes the response strobe aligned with ram_result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rsp_vld_p1 <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rsp_vld_p1 <= w_grant & ~req_we;
        end
    end

    assign rsp_valid = r_rsp_vld_p1;
    assign rsp_data  = ram_result;
    assign busy      = (r_state == CLEAR);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1R/1W registered-read Ram attached.
module tb_ram_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int N_REQ  = 2;
    localparam int SIZE   = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    clear;
    logic                    busy;
    logic [ADDR_W-1:0]       ram_ra;
    logic [ADDR_W-1:0]       ram_wa;
    logic [DATA_W-1:0]       ram_data;
    logic                    ram_we;
    logic [DATA_W-1:0]       ram_result;

    logic [DATA_W-1:0]       mem [SIZE];

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clear(clear), .busy(busy),
        .ram_ra(ram_ra), .ram_wa(ram_wa), .ram_data(ram_data), .ram_we(ram_we),
        .ram_result(ram_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_data;
        ram_result <= mem[ram_ra];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1, input logic clr);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        clear     = clr;
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        ram_result = '0;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ram_we", 32'(ram_we), 0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: write then read back through the other requester
        drive(2'b01, 2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0, 1'b0);
        chk("t1_ready0", 32'(req_ready), 1);
        chk("t1_ram_we", 32'(ram_we), 1);
        chk("t1_ram_wa", 32'(ram_wa), 3);
        chk("t1_ram_data", 32'(ram_data), 32'hBEEF);
        drive(2'b10, 2'b00, 4'd0, 4'd3, 16'h0, 16'h0, 1'b0);
        chk("t1_ready1", 32'(req_ready), 2);
        chk("t1_read_we", 32'(ram_we), 0);
        chk("t1_ram_ra", 32'(ram_ra), 3);
        chk("t1_no_rsp_for_write", 32'(rsp_valid), 0);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t1_rsp_valid", 32'(rsp_valid), 2);
        chk("t1_rsp_data", 32'(rsp_data), 32'hBEEF);
        chk("t1_idle_ready", 32'(req_ready), 0);

        // Test 2: contention between two readers for 4 cycles
        prev_g = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 4'd1, 4'd2, 16'h0, 16'h0, 1'b0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("t2_grant", 32'(req_ready), 32'(exp_g));
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(prev_g));
            chk("t2_ram_ra", 32'(ram_ra), (exp_g == 2'b01) ? 1 : 2);
            prev_g = exp_g;
        end
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t2_last_rsp", 32'(rsp_valid), 32'(prev_g));

        // Test 3: fill with 00FF, clear, verify sweep and zeroed contents
        for (int i = 0; i < SIZE; i++) begin
            drive(2'b01, 2'b01, 4'(i), 4'd0, 16'h00FF, 16'h0, 1'b0);
            chk("t3_fill_wa", 32'(ram_wa), i);
        end
        drive(2'b01, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
        chk("t3_clear_no_grant", 32'(req_ready), 0);
        chk("t3_clear_busy_low", 32'(busy), 0);
        chk("t3_clear_no_we", 32'(ram_we), 0);
        for (int i = 0; i < SIZE; i++) begin
            drive(2'b01, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
            chk("t3_sweep_busy", 32'(busy), 1);
            chk("t3_sweep_we", 32'(ram_we), 1);
            chk("t3_sweep_wa", 32'(ram_wa), i);
            chk("t3_sweep_data", 32'(ram_data), 0);
            chk("t3_sweep_ready", 32'(req_ready), 0);
        end
        for (int i = 0; i < SIZE; i++) begin
            drive(2'b01, 2'b00, 4'(i), 4'd0, 16'h0, 16'h0, 1'b0);
            chk("t3_post_ready", 32'(req_ready), 1);
            chk("t3_post_busy", 32'(busy), 0);
            if (i > 0) begin
                chk("t3_rd_valid", 32'(rsp_valid), 1);
                chk("t3_rd_zero", 32'(rsp_data), 0);
            end
        end
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t3_rd_last_valid", 32'(rsp_valid), 1);
        chk("t3_rd_last_zero", 32'(rsp_data), 0);

        // Test 4 + 5: read right before clear, then a second clear mid-sweep
        drive(2'b01, 2'b01, 4'd9, 4'd0, 16'h1234, 16'h0, 1'b0);
        drive(2'b01, 2'b00, 4'd9, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t4_read_ready", 32'(req_ready), 1);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
        chk("t4_rsp_valid", 32'(rsp_valid), 1);
        chk("t4_rsp_data", 32'(rsp_data), 32'h1234);
        chk("t4_clear_no_grant", 32'(req_ready), 0);
        for (int i = 0; i < SIZE; i++) begin
            drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, (i == 5));
            chk("t45_busy", 32'(busy), 1);
            chk("t45_wa", 32'(ram_wa), i);
            if (i == 0) chk("t4_rsp_once", 32'(rsp_valid), 0);
        end
        drive(2'b01, 2'b00, 4'd9, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t5_busy_dropped", 32'(busy), 0);
        chk("t5_ready_live", 32'(req_ready), 1);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t5_cleared_data", 32'(rsp_data), 0);
        chk("t5_rsp_valid", 32'(rsp_valid), 1);

        // Test 6: reset mid-sweep at cnt=7
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
            chk("t6_wa", 32'(ram_wa), i);
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_rsp", 32'(rsp_valid), 0);
        chk("t6_rst_we", 32'(ram_we), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 2'b00, 4'd3, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t6_ready_live", 32'(req_ready), 1);
        chk("t6_busy_low", 32'(busy), 0);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
        chk("t6_rsp_valid", 32'(rsp_valid), 1);
        chk("t6_rsp_zero", 32'(rsp_data), 0);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t6_restart_busy", 32'(busy), 1);
        chk("t6_restart_wa0", 32'(ram_wa), 0);
        drive(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
        chk("t6_restart_wa1", 32'(ram_wa), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
